// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pool_pkg
// Description : Shared types and helpers for the conv2 2x2 max-pool stage.
//               feat_t   - one signed feature word
//               feat3_t  - one 3-channel pixel, channels [3:1]
//               max2     - signed maximum of two feature words
//               pool_state_t - frame sequencing states
// Revision    : 1.0 - initial release
// ============================================================================
package pool_pkg;

    // Feature word width, two's complement.
    localparam int DW = 16;

    typedef logic signed [DW-1:0] feat_t;
    typedef feat_t feat3_t [3:1];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } pool_state_t;

    // Signed maximum. Ties return b; the values are identical, so either is bit-exact.
    function automatic feat_t max2(input feat_t a, input feat_t b);
        return (a > b) ? a : b;
    endfunction

endpackage : pool_pkg
`default_nettype wire

// File: rtl/pool_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pool_line_buffer
// Description : Half-row store of 3-channel horizontal pair maxima. One entry
//               per pooled column; written on even rows, read on odd rows.
//               No reset: contents are only read after being written in the
//               same frame.
// Ports       : clk        - clock
//               wr_en_i    - write strobe
//               wr_addr_i  - write entry (col>>1)
//               wr_data_i  - pixel to store
//               rd_addr_i  - read entry (col>>1)
//               rd_data_o  - combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module pool_line_buffer
    import pool_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  feat3_t        wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output feat3_t        rd_data_o
);

    feat3_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : pool_line_buffer
`default_nettype wire

// File: rtl/pool_layer2.sv
`default_nettype none
// ============================================================================
// Module      : pool_layer2
// Description : 2x2 stride-2 max pooling of the 3-channel conv2 feature
//               stream. Accepts one raster-order pixel per transfer, emits
//               one pooled pixel per 2x2 window, pulses frame_done once the
//               last pooled pixel has been taken downstream.
// Ports       : clk, reset    - clock, synchronous active-high reset
//               start         - begin a frame (honoured only in IDLE)
//               in_valid      - in_feature valid
//               in_feature    - conv2 pixel, channels [3:1]
//               ready_pool    - block accepts in_feature this cycle
//               out_feature   - pooled pixel, channels [3:1]
//               out_valid     - out_feature valid, held until out_ready
//               out_ready     - downstream accepts out_feature
//               frame_done    - one-cycle end-of-frame pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pool_layer2
    import pool_pkg::*;
#(
    parameter int MAP_W = 10,
    parameter int MAP_H = 10
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  logic   in_valid,
    input  feat3_t in_feature,
    output logic   ready_pool,
    output feat3_t out_feature,
    output logic   out_valid,
    input  logic   out_ready,
    output logic   frame_done
);

    localparam int CW    = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int RW    = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int DEPTH = MAP_W / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] C_COL_LAST = CW'(MAP_W - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(MAP_H - 1);

    pool_state_t   state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    feat3_t hold_q;
    feat3_t out_q;
    logic   out_valid_q;

    feat3_t w_lb_rd;
    feat3_t w_pair_max;
    feat3_t w_win_max;
    logic   w_xfer;
    logic   w_last;
    logic   w_lb_we;
    logic   w_load;
    logic [AW-1:0] w_lb_addr;

    // Stall intake only while a result is stuck in the output register;
    // a result being accepted this cycle frees the slot for a new load.
    assign ready_pool = (state_q == RUN) && !(out_valid_q && !out_ready);
    assign w_xfer     = in_valid && ready_pool;
    assign w_last     = (row_q == C_ROW_LAST) && (col_q == C_COL_LAST);

    // Odd column closes a horizontal pair; row parity decides whether the
    // pair is parked in the line buffer or combined into a finished window.
    assign w_lb_we   = w_xfer && col_q[0] && !row_q[0];
    assign w_load    = w_xfer && col_q[0] &&  row_q[0];
    assign w_lb_addr = AW'(col_q >> 1);

    always_comb begin
        w_pair_max = '{default: '0};
        w_win_max  = '{default: '0};
        for (int ch = 1; ch <= 3; ch++) begin
            w_pair_max[ch] = max2(hold_q[ch], in_feature[ch]);
            w_win_max[ch]  = max2(w_lb_rd[ch], w_pair_max[ch]);
        end
    end

    pool_line_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_line_buffer (
        .clk       (clk),
        .wr_en_i   (w_lb_we),
        .wr_addr_i (w_lb_addr),
        .wr_data_i (w_pair_max),
        .rd_addr_i (w_lb_addr),
        .rd_data_o (w_lb_rd)
    );

    // ------------------------------------------------------------------
    // Frame sequencing and raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                if (w_xfer) begin
                    if (col_q == C_COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == C_ROW_LAST) ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (w_last) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_valid_q && out_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pair hold register and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q      <= '{default: '0};
            out_q       <= '{default: '0};
            out_valid_q <= 1'b0;
        end else begin
            if (w_xfer && !col_q[0]) begin
                hold_q <= in_feature;
            end
            if (w_load) begin
                out_q       <= w_win_max;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_feature = out_q;
    assign out_valid   = out_valid_q;
    assign frame_done  = (state_q == DONE);

endmodule : pool_layer2
`default_nettype wire

// File: tb/tb_pool_layer2.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_layer2
// Description : Self-checking bench for pool_layer2. Two instances (4x4 and
//               10x10 maps) share stimulus; 'sel' chooses which one is
//               started and observed. Expected pooled pixels come from a
//               direct window-maximum model over the stored input image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_layer2;
    import pool_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    logic   start;
    logic   in_valid;
    feat3_t in_feature;
    logic   out_ready;
    logic   sel;

    logic   rdy_a, val_a, done_a;
    logic   rdy_b, val_b, done_b;
    feat3_t of_a, of_b;

    logic        obs_ready, obs_valid, obs_done;
    logic [47:0] obs_feat;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] img [10][10][3];
    logic [47:0] got [$];
    logic [47:0] exp_q [$];

    always #5 clk = ~clk;

    pool_layer2 #(.MAP_W(4), .MAP_H(4)) dut_a (
        .clk(clk), .reset(reset), .start(start && !sel), .in_valid(in_valid),
        .in_feature(in_feature), .ready_pool(rdy_a), .out_feature(of_a),
        .out_valid(val_a), .out_ready(out_ready), .frame_done(done_a)
    );

    pool_layer2 #(.MAP_W(10), .MAP_H(10)) dut_b (
        .clk(clk), .reset(reset), .start(start && sel), .in_valid(in_valid),
        .in_feature(in_feature), .ready_pool(rdy_b), .out_feature(of_b),
        .out_valid(val_b), .out_ready(out_ready), .frame_done(done_b)
    );

    always_comb begin
        obs_ready = sel ? rdy_b  : rdy_a;
        obs_valid = sel ? val_b  : val_a;
        obs_done  = sel ? done_b : done_a;
        obs_feat  = sel ? {of_b[3], of_b[2], of_b[1]} : {of_a[3], of_a[2], of_a[1]};
    end

    // Random image of w x h pixels.
    task automatic fill_random(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                for (int ch = 0; ch < 3; ch++)
                    img[r][c][ch] = 16'($urandom);
    endtask

    // Reference: each pooled pixel is the per-channel maximum of its 2x2 window.
    task automatic build_expected(input int w, input int h);
        exp_q.delete();
        for (int pr = 0; pr < h / 2; pr++) begin
            for (int pc = 0; pc < w / 2; pc++) begin
                logic [47:0] e;
                e = '0;
                for (int ch = 0; ch < 3; ch++) begin
                    logic signed [15:0] m;
                    m = img[2*pr][2*pc][ch];
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            if (img[2*pr+dr][2*pc+dc][ch] > m) m = img[2*pr+dr][2*pc+dc][ch];
                    e[ch*16 +: 16] = m;
                end
                exp_q.push_back(e);
            end
        end
    endtask

    // Streams pixels from first_idx onward, records every accepted output in
    // 'got', counts frame_done pulses, and stops a few cycles after the first.
    task automatic drive_frame(input int w, input int h, input int first_idx,
                               input bit do_start, input int vpct, input int rpct,
                               input int spur_cyc, output int ndone, output bit tmo);
        int idx;
        int extra;
        idx   = first_idx;
        extra = 0;
        ndone = 0;
        tmo   = 1'b1;
        if (do_start) begin
            @(negedge clk);
            start    = 1'b1;
            in_valid = 1'b0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            start    = (cyc == spur_cyc);
            in_valid = (idx < w*h) && ($urandom_range(99) < vpct);
            if (idx < w*h)
                for (int ch = 0; ch < 3; ch++) in_feature[ch+1] = img[idx/w][idx%w][ch];
            out_ready = ($urandom_range(99) < rpct);
            #1;
            if (obs_done) ndone++;
            if (in_valid && obs_ready) idx++;
            if (obs_valid && out_ready) got.push_back(obs_feat);
            if (ndone > 0) begin
                extra++;
                if (extra > 4) begin
                    tmo = 1'b0;
                    break;
                end
            end
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
        in_feature = '{default: '0};
        repeat (3) @(negedge clk);
        checks++;
        if ({rdy_a, val_a, done_a, of_a[3], of_a[2], of_a[1]} !== '0) begin
            errors++;
            $display("FAIL reset_a: got rdy=%b val=%b done=%b feat=%h, want all 0",
                     rdy_a, val_a, done_a, {of_a[3], of_a[2], of_a[1]});
        end
        checks++;
        if ({rdy_b, val_b, done_b, of_b[3], of_b[2], of_b[1]} !== '0) begin
            errors++;
            $display("FAIL reset_b: got rdy=%b val=%b done=%b feat=%h, want all 0",
                     rdy_b, val_b, done_b, {of_b[3], of_b[2], of_b[1]});
        end
        reset = 1'b0;
    endtask

    task automatic test_ramp_4x4();
        int  c1 [4] = '{5, 7, 13, 15};
        int  c2 [4] = '{0, -2, -8, -10};
        int  nd;
        bit  tmo;
        logic [47:0] e;
        sel = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                img[r][c][0] = 16'(r*4 + c);
                img[r][c][1] = 16'(-(r*4 + c));
                img[r][c][2] = 16'(7);
            end
        got.delete();
        drive_frame(4, 4, 0, 1'b1, 100, 100, -1, nd, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL ramp_timeout: frame_done not seen"); end
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL ramp_count: got %0d outputs, want 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            e = {16'(7), 16'(c2[i]), 16'(c1[i])};
            checks++;
            if (got[i] !== e) begin
                errors++; $display("FAIL ramp_px%0d: got %h, want %h", i, got[i], e);
            end
        end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL ramp_done: %0d pulses, want 1", nd); end
    endtask

    task automatic test_signs();
        int nd;
        bit tmo;
        logic [47:0] g;
        sel = 1'b0;
        fill_random(4, 4);
        img[0][0][0] = -16'sd32768; img[0][1][0] = 16'sd32767;
        img[1][0][0] = -16'sd1;     img[1][1][0] = 16'sd0;
        img[0][2][0] = -16'sd5;     img[0][3][0] = -16'sd3;
        img[1][2][0] = -16'sd9;     img[1][3][0] = -16'sd4;
        build_expected(4, 4);
        got.delete();
        drive_frame(4, 4, 0, 1'b1, 70, 60, -1, nd, tmo);
        checks++;
        if (tmo || got.size() != 4) begin
            errors++; $display("FAIL signs_count: got %0d outputs tmo=%b, want 4", got.size(), tmo);
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL signs_px%0d: got %h, want %h", i, got[i], exp_q[i]);
            end
        end
        if (got.size() >= 2) begin
            g = got[0];
            checks++;
            if (g[15:0] !== 16'h7FFF) begin
                errors++; $display("FAIL signs_mixed: got %h, want 7fff", g[15:0]);
            end
            g = got[1];
            checks++;
            if (g[15:0] !== 16'hFFFD) begin
                errors++; $display("FAIL signs_neg: got %h, want fffd", g[15:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int bad = 0;
        bit seen = 1'b0;
        int nd;
        bit tmo;
        sel = 1'b0;
        fill_random(4, 4);
        build_expected(4, 4);
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            start     = 1'b0;
            in_valid  = 1'b1;
            for (int ch = 0; ch < 3; ch++) in_feature[ch+1] = img[idx/4][idx%4][ch];
            out_ready = 1'b0;
            #1;
            if (obs_valid) begin
                seen = 1'b1;
                if (obs_feat !== exp_q[0]) bad++;
            end
            if (in_valid && obs_ready) idx++;
        end
        checks++;
        if (idx != 6) begin errors++; $display("FAIL bp_taken: %0d pixels taken, want 6", idx); end
        checks++;
        if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b, want 0", obs_ready); end
        checks++;
        if (!seen || bad != 0 || obs_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: valid=%b seen=%b unstable=%0d, want held %h",
                               obs_valid, seen, bad, exp_q[0]);
        end
        got.delete();
        drive_frame(4, 4, idx, 1'b0, 100, 100, -1, nd, tmo);
        checks++;
        if (tmo || got.size() != 4 || nd != 1) begin
            errors++; $display("FAIL bp_count: got %0d outputs done=%0d tmo=%b, want 4/1", got.size(), nd, tmo);
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_px%0d: got %h, want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_10x10();
        int nd;
        bit tmo;
        sel = 1'b1;
        fill_random(10, 10);
        build_expected(10, 10);
        got.delete();
        drive_frame(10, 10, 0, 1'b1, 50, 75, -1, nd, tmo);
        checks++;
        if (tmo || got.size() != 25) begin
            errors++; $display("FAIL rand_count: got %0d outputs tmo=%b, want 25", got.size(), tmo);
        end
        for (int i = 0; i < 25 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_px%0d: got %h, want %h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL rand_done: %0d pulses, want 1", nd); end
    endtask

    task automatic test_reset_midframe();
        int idx = 0;
        int nd;
        bit tmo;
        sel = 1'b1;
        fill_random(10, 10);
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 200 && idx < 35; cyc++) begin
            @(negedge clk);
            start     = 1'b0;
            in_valid  = 1'b1;
            for (int ch = 0; ch < 3; ch++) in_feature[ch+1] = img[idx/10][idx%10][ch];
            out_ready = 1'b1;
            #1;
            if (in_valid && obs_ready) idx++;
        end
        checks++;
        if (idx != 35) begin errors++; $display("FAIL mid_reach: idx %0d, want 35", idx); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({obs_ready, obs_valid, obs_done, obs_feat} !== '0) begin
            errors++; $display("FAIL mid_reset: rdy=%b val=%b done=%b feat=%h, want all 0",
                               obs_ready, obs_valid, obs_done, obs_feat);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        fill_random(10, 10);
        build_expected(10, 10);
        got.delete();
        drive_frame(10, 10, 0, 1'b1, 80, 80, -1, nd, tmo);
        checks++;
        if (tmo || got.size() != 25 || nd != 1) begin
            errors++; $display("FAIL mid_count: got %0d outputs done=%0d tmo=%b, want 25/1", got.size(), nd, tmo);
        end
        for (int i = 0; i < 25 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL mid_px%0d: got %h, want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_ignored();
        int bad = 0;
        int nd;
        bit tmo;
        sel = 1'b0;
        fill_random(4, 4);
        build_expected(4, 4);
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1;
            for (int ch = 0; ch < 3; ch++) in_feature[ch+1] = 16'($urandom);
            #1;
            if (obs_ready !== 1'b0 || obs_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_ready: %0d cycles ready/valid high, want 0", bad); end
        in_valid = 1'b0;
        got.delete();
        drive_frame(4, 4, 0, 1'b1, 100, 100, 5, nd, tmo);
        checks++;
        if (tmo || got.size() != 4 || nd != 1) begin
            errors++; $display("FAIL ign_count: got %0d outputs done=%0d tmo=%b, want 4/1", got.size(), nd, tmo);
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL ign_px%0d: got %h, want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_4x4();
        test_signs();
        test_backpressure();
        test_random_10x10();
        test_reset_midframe();
        test_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pool_layer2
`default_nettype wire
